// File: rtl/matvec_param.sv
// matvec_param: signed N x N matrix-vector multiplier, y = M*x.
// A matrix stream (optional) plus a vector stream go in, N results come out
// one per handshake. One MAC per cycle; each row takes N+1 cycles, where
// the extra cycle registers the ReLU/saturated result. The matrix is kept
// between transactions and reused until a new one is streamed in.
module matvec_param #(
    parameter int N  = 8,
    parameter int IW = 14,
    parameter int OW = 28
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [IW-1:0] input_data,
    input  logic                 new_matrix,
    input  logic                 relu_en,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic signed [OW-1:0] output_data,
    output logic                 output_sat
);
    localparam int AW  = 2*IW + $clog2(N);
    localparam int NN  = N*N;
    localparam int CW  = $clog2(NN+1);
    localparam int MIW = $clog2(NN);
    localparam int XIW = $clog2(N);
    localparam int KW  = $clog2(N+1);

    typedef enum logic [2:0] {S_IDLE, S_LOADM, S_LOADV, S_MAC, S_OUT} state_t;
    state_t state, state_nx;

    logic [CW-1:0]         cnt;
    logic [XIW-1:0]        row;
    logic [KW-1:0]         col;
    logic                  mat_loaded, relu_q, rdy_en;
    logic signed [AW-1:0]  acc;
    logic signed [IW-1:0]  mem [NN];
    logic signed [IW-1:0]  xv  [N];

    logic in_fire, out_fire, last_m, last_v, last_row, mac_done;
    assign in_fire  = input_valid & input_ready;
    assign out_fire = output_valid & output_ready;
    assign last_m   = (cnt == CW'(NN-1));
    assign last_v   = (cnt == CW'(N-1));
    assign last_row = (row == XIW'(N-1));
    // col == N is the extra cycle that registers the finished row
    assign mac_done = (col == KW'(N));

    // Product of the current matrix/vector pair; an unloaded matrix reads as zeros
    logic [MIW-1:0]          midx;
    logic signed [2*IW-1:0]  prod_raw, prod;
    assign midx     = MIW'(row) * MIW'(N) + MIW'(col);
    assign prod_raw = mem[midx] * xv[col[XIW-1:0]];
    assign prod     = mat_loaded ? prod_raw : '0;

    // ReLU first, then clamp into the OW-bit output range
    logic signed [AW-1:0] relu_v;
    logic signed [OW-1:0] res;
    logic                 sat;
    assign relu_v = (relu_q && acc[AW-1]) ? '0 : acc;

    generate
        if (OW < AW) begin : g_sat
            localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            // Saturate to [-2^(OW-1), 2^(OW-1)-1] and flag any clamp
            always_comb begin
                res = relu_v[OW-1:0];
                sat = 1'b0;
                if (relu_v > MAXV) begin
                    res = MAXV[OW-1:0];
                    sat = 1'b1;
                end else if (relu_v < MINV) begin
                    res = MINV[OW-1:0];
                    sat = 1'b1;
                end
            end
        end else begin : g_ext
            assign res = OW'(relu_v);
            assign sat = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_fire) state_nx = new_matrix ? S_LOADM : S_LOADV;
            S_LOADM: if (in_fire && last_m) state_nx = S_LOADV;
            S_LOADV: if (in_fire && last_v) state_nx = S_MAC;
            S_MAC:   if (mac_done) state_nx = S_OUT;
            S_OUT:   if (out_fire) state_nx = last_row ? S_IDLE : S_MAC;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs; input_ready is held off until the first edge after reset
    always_comb begin
        input_ready  = rdy_en && (state == S_IDLE || state == S_LOADM || state == S_LOADV);
        output_valid = (state == S_OUT);
    end

    // Ready enable comes up one edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // Counters, accumulator, per-transaction flags and the output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            mat_loaded  <= 1'b0;
            relu_q      <= 1'b0;
            output_data <= '0;
            output_sat  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_fire) begin
                    relu_q <= relu_en;
                    cnt    <= CW'(1);
                end
                S_LOADM: if (in_fire) begin
                    if (last_m) begin
                        cnt        <= '0;
                        mat_loaded <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOADV: if (in_fire) begin
                    if (last_v) begin
                        cnt <= '0;
                        row <= '0;
                        col <= '0;
                        acc <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MAC: begin
                    if (!mac_done) begin
                        acc <= acc + AW'(prod);
                        col <= col + KW'(1);
                    end else begin
                        output_data <= res;
                        output_sat  <= sat;
                    end
                end
                S_OUT: if (out_fire && !last_row) begin
                    row <= row + XIW'(1);
                    col <= '0;
                    acc <= '0;
                end
                default: ;
            endcase
        end
    end

    // Matrix and vector storage; survives reset, only written on accepted words
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if ((state == S_IDLE && new_matrix) || state == S_LOADM)
                mem[cnt[MIW-1:0]] <= input_data;
            if ((state == S_IDLE && !new_matrix) || state == S_LOADV)
                xv[cnt[XIW-1:0]] <= input_data;
        end
    end

endmodule

// File: tb/tb_matvec_param.sv
// tb_matvec_param: directed test of matvec_param. Two instances share one
// stimulus stream: OW=28 (main) and OW=16 (narrow, exercises saturation).
module tb_matvec_param;
    localparam int N  = 8;
    localparam int IW = 14;

    logic clk = 1'b0, reset_n = 1'b0;
    logic input_valid = 1'b0, new_matrix = 1'b0, relu_en = 1'b0, output_ready = 1'b0;
    logic signed [IW-1:0] input_data = '0;
    logic in_rdy_m, in_rdy_s, ov_m, ov_s, sat_m, sat_s;
    logic signed [27:0] od_m;
    logic signed [15:0] od_s;

    int checks = 0, errors = 0, hs_cnt = 0;
    int m_a [64];
    int xs  [2][8];
    int ey_m[6][8];
    int ey_s[6][8];
    int es  [6];

    matvec_param #(.N(N), .IW(IW), .OW(28)) u_dut (
        .clk(clk), .reset_n(reset_n), .input_valid(input_valid), .input_ready(in_rdy_m),
        .input_data(input_data), .new_matrix(new_matrix), .relu_en(relu_en),
        .output_valid(ov_m), .output_ready(output_ready), .output_data(od_m), .output_sat(sat_m)
    );

    matvec_param #(.N(N), .IW(IW), .OW(16)) u_sat (
        .clk(clk), .reset_n(reset_n), .input_valid(input_valid), .input_ready(in_rdy_s),
        .input_data(input_data), .new_matrix(new_matrix), .relu_en(relu_en),
        .output_valid(ov_s), .output_ready(output_ready), .output_data(od_s), .output_sat(sat_s)
    );

    always #5 clk = ~clk;

    // Count output handshakes on the main instance
    always @(posedge clk) if (ov_m && output_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mword(input int msel, input int i);
        if (msel == 1) return 8191;
        if (msel == 2) return -8192;
        return m_a[i];
    endfunction

    function automatic int xword(input int xsel, input int i);
        if (xsel == 2) return 8191;
        return xs[xsel][i];
    endfunction

    task automatic send_word(input int d, input logic nm, input logic re, input bit gaps);
        int t;
        if (gaps) while ($urandom_range(1, 0) == 1) @(negedge clk);
        input_valid = 1'b1;
        input_data  = IW'(d);
        new_matrix  = nm;
        relu_en     = re;
        t = 0;
        while (!in_rdy_m && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("input_ready", in_rdy_m, 1);
        chk("input_ready_s", in_rdy_s, 1);
        @(negedge clk);
        input_valid = 1'b0;
        input_data  = 'x;
        new_matrix  = 1'b0;
        relu_en     = 1'b0;
    endtask

    // First word carries new_matrix/relu_en; later words drive the opposite to show they are ignored
    task automatic send_txn(input int msel, input int xsel, input logic nm, input logic re, input bit gaps);
        bit first = 1'b1;
        if (nm) begin
            for (int i = 0; i < N*N; i++) begin
                send_word(mword(msel, i), first ? 1'b1 : 1'b1, first ? re : ~re, gaps);
                first = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            send_word(xword(xsel, i), first ? nm : 1'b1, first ? re : ~re, gaps);
            first = 1'b0;
        end
    endtask

    task automatic recv_word(input int set, input int r, input bit gaps);
        int t = 0;
        bit seen = 1'b0;
        logic signed [27:0] first_d = '0;
        while (1) begin
            output_ready = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            if (ov_m && !seen) begin
                seen    = 1'b1;
                first_d = od_m;
            end
            if (ov_m && output_ready) break;
            if (t >= 300) break;
            @(negedge clk);
            t++;
        end
        chk($sformatf("t%0d_valid[%0d]", set, r), ov_m, 1);
        chk($sformatf("t%0d_y[%0d]", set, r), od_m, ey_m[set][r]);
        chk($sformatf("t%0d_sat[%0d]", set, r), sat_m, es[set]);
        chk($sformatf("t%0d_valid_s[%0d]", set, r), ov_s, 1);
        chk($sformatf("t%0d_y_s[%0d]", set, r), od_s, ey_s[set][r]);
        chk($sformatf("t%0d_sat_s[%0d]", set, r), sat_s, es[set]);
        if (gaps) chk($sformatf("t%0d_stable[%0d]", set, r), od_m, first_d);
        @(negedge clk);
        output_ready = 1'b0;
    endtask

    task automatic recv_vec(input int set, input bit gaps);
        for (int r = 0; r < N; r++) recv_word(set, r, gaps);
    endtask

    initial begin
        int lat, base, quiet;
        // Matrix: row0 given, row1 chosen so y[1] = -13810 for the second vector,
        // rows 2..7 are +/-1 on the diagonal (even rows +1, odd rows -1).
        for (int i = 0; i < 64; i++) m_a[i] = 0;
        m_a[0:7] = '{10, -20, 30, -40, 50, -60, 70, 80};
        m_a[8:15] = '{0, 0, 0, -200, 0, 30, 0, -30};
        for (int r = 2; r < 8; r++) m_a[r*8 + r] = (r % 2 == 1) ? -1 : 1;
        xs[0] = '{-50, 40, 32, -16, 11, -49, 49, 111};
        xs[1] = '{22, -41, 42, 62, 4, -55, 7, -8};
        ey_m[0] = '{16100, -1600, 32, 16, 11, 49, 49, -111};
        ey_m[1] = '{3170, -13810, 42, -62, 4, 55, 7, 8};
        ey_m[2] = '{3170, 0, 42, 0, 4, 55, 7, 8};
        for (int r = 0; r < 8; r++) begin
            ey_m[3][r] = 134217727;
            ey_m[4][r] = -134217728;
            ey_m[5][r] = 0;
        end
        ey_s = ey_m;
        for (int r = 0; r < 8; r++) begin
            ey_s[3][r] = 32767;
            ey_s[4][r] = -32768;
        end
        es = '{0, 0, 0, 1, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_input_ready", in_rdy_m, 0);
        chk("rst_output_valid", ov_m, 0);
        chk("rst_output_data", od_m, 0);
        chk("rst_output_sat", sat_m, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_rdy_m, 1);

        // Test 1: load matrix, first vector, latency of y[0]
        send_txn(0, 0, 1'b1, 1'b0, 1'b0);
        lat = 0;
        while (!ov_m && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_y0", lat, N + 1);
        recv_vec(0, 1'b0);

        // Test 2: reuse the matrix
        send_txn(0, 1, 1'b0, 1'b0, 1'b0);
        recv_vec(1, 1'b0);

        // Test 3: same with ReLU
        send_txn(0, 1, 1'b0, 1'b1, 1'b0);
        recv_vec(2, 1'b0);

        // Test 5: random gaps on both sides
        base = hs_cnt;
        send_txn(0, 0, 1'b1, 1'b0, 1'b1);
        recv_vec(0, 1'b1);
        send_txn(0, 1, 1'b0, 1'b0, 1'b1);
        recv_vec(1, 1'b1);
        @(negedge clk);
        chk("handshakes", hs_cnt - base, 16);
        output_ready = 1'b1;
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (ov_m || ov_s) quiet++;
        end
        output_ready = 1'b0;
        chk("quiet_after", quiet, 0);

        // Test 4: saturation both ways, then ReLU ahead of saturation
        send_txn(1, 2, 1'b1, 1'b0, 1'b0);
        recv_vec(3, 1'b0);
        send_txn(2, 2, 1'b1, 1'b0, 1'b0);
        recv_vec(4, 1'b0);
        send_txn(2, 2, 1'b0, 1'b1, 1'b0);
        recv_vec(5, 1'b0);

        // Test 6: reset mid-load discards the matrix
        for (int i = 0; i < 20; i++) send_word(m_a[i], 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_input_ready", in_rdy_m, 0);
        chk("midrst_output_valid", ov_m, 0);
        chk("midrst_output_data", od_m, 0);
        reset_n = 1'b1;
        @(negedge clk);
        send_txn(0, 0, 1'b0, 1'b0, 1'b0);
        recv_vec(5, 1'b0);
        send_txn(0, 0, 1'b1, 1'b0, 1'b0);
        recv_vec(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
